// File: rtl/bfp_vt_sched.sv
// Round-robin arbiter sharing one vectTran among NREQ requesters: grant, latch vector, count beats, ack.
// Optional watchdog enabled by defining BFP_VT_WDOG_EN.
module bfp_vt_sched #(
  parameter int NREQ     = 2,
  parameter int V        = 8,
  parameter int P        = 4,
  parameter int BIT      = 32,
  parameter int WDOG_CYC = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ*V*BIT-1:0]     req_vec_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic [NREQ-1:0]           ack_o,
  output logic                      busy_o,
  output logic [V*BIT-1:0]          vt_vector_o,
  output logic                      vt_vector_rdy_o,
  input  logic                      vt_valid_out_i,
  input  logic                      vt_done_i,
  output logic [$clog2(V/P):0]      beat_cnt_o,
  output logic                      beat_err_o,
  output logic                      wdog_err_o
);
  localparam int IW    = $clog2(NREQ);
  localparam int BEATS = V / P;
  localparam int CW    = $clog2(V/P) + 1;
  localparam int VW    = V * BIT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  if (NREQ < 2 || (V % P) != 0 || WDOG_CYC < 1) begin : g_param_err
    $error("bfp_vt_sched: illegal parameter set");
  end

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] win_q, win_d, rr_q, rr_d, pick;
  logic [VW-1:0] vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          found;
  logic          timeout;
  int            idx;

  // First requester at or after rr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

`ifdef BFP_VT_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0] wd_q;
  logic          wderr_q;

  assign timeout = (state_q == S_RUN) && !vt_done_i && (wd_q == WW'(WDOG_CYC - 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wd_q    <= '0;
      wderr_q <= 1'b0;
    end else begin
      wd_q    <= (state_q == S_RUN) ? wd_q + 1'b1 : '0;
      wderr_q <= timeout;
    end
  end

  assign wdog_err_o = (state_q == S_ACK) && wderr_q;
`else
  assign timeout    = 1'b0;
  assign wdog_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (found) begin
        state_d = S_RUN;
        win_d   = pick;
        vec_d   = req_vec_i[int'(pick)*VW +: VW];
        cnt_d   = '0;
      end
      S_RUN: begin
        if (vt_valid_out_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (vt_done_i || timeout) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
        rr_d    = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o           = {{(NREQ-1){1'b0}}, state_q == S_RUN} << win_q;
  assign ack_o           = {{(NREQ-1){1'b0}}, state_q == S_ACK} << win_q;
  assign busy_o          = (state_q != S_IDLE);
  assign vt_vector_rdy_o = (state_q == S_RUN);
  assign vt_vector_o     = vec_q;
  assign beat_cnt_o      = cnt_q;
  assign beat_err_o      = (state_q == S_ACK) && (cnt_q != CW'(BEATS));

endmodule

// File: tb/tb_bfp_vt_sched.sv
// Directed + randomized bench for bfp_vt_sched against a round-robin job model.
module tb_bfp_vt_sched;
  localparam int NREQ = 2, V = 8, P = 4, BIT = 32, WDOG = 8;
  localparam int W = V * BIT;
  localparam int BEATS = V / P;
  localparam int SAT = 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*W-1:0]     req_vec;
  logic [NREQ-1:0]       gnt, ack;
  logic                  busy, rdy, valid, done, beat_err, wdog_err;
  logic [W-1:0]          vt_vector;
  logic [1:0]            beat_cnt;
  logic [NREQ-1:0][W-1:0] vecs;

  int total = 0;
  int bad   = 0;
  int rr    = 0;

  bfp_vt_sched #(.NREQ(NREQ), .V(V), .P(P), .BIT(BIT), .WDOG_CYC(WDOG)) dut (
    .clk_i(clk), .reset_i(reset_n), .req_i(req), .req_vec_i(req_vec),
    .gnt_o(gnt), .ack_o(ack), .busy_o(busy), .vt_vector_o(vt_vector),
    .vt_vector_rdy_o(rdy), .vt_valid_out_i(valid), .vt_done_i(done),
    .beat_cnt_o(beat_cnt), .beat_err_o(beat_err), .wdog_err_o(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic new_vecs();
    for (int r = 0; r < NREQ; r++)
      for (int e = 0; e < V; e++)
        vecs[r][e*BIT +: BIT] = $urandom();
    req_vec = vecs;
  endtask

  // One complete job from IDLE: grant, nbeats beats, done, ack, one idle cycle.
  task automatic run_job(input int nbeats, input bit merge, input bit gaps, input bit drop);
    int w;
    int seen;
    logic [W-1:0] ev;
    w  = rr_pick(req, rr);
    tick();
    ev = vecs[w];
    chk("gnt", gnt, 1 << w);
    chk("rdy", rdy, 1);
    chk("busy_run", busy, 1);
    chk("vec", vt_vector, ev);
    chk("cnt0", beat_cnt, 0);
    new_vecs();
    if (drop) req[w] = 1'b0;
    seen = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        valid = 1'b0; done = 1'b0; tick();
      end
      valid = 1'b1;
      done  = merge && (i == nbeats - 1);
      tick();
      seen++;
      chk("cnt", beat_cnt, (seen > SAT) ? SAT : seen);
      if (!done) chk("gnt_hold", {gnt, rdy}, {2'(1 << w), 1'b1});
    end
    if (!(merge && nbeats > 0)) begin
      valid = 1'b0; done = 1'b1; tick();
    end
    valid = 1'b0; done = 1'b0;
    chk("ack", ack, 1 << w);
    chk("ack_gnt_rdy", {gnt, rdy}, 0);
    chk("ack_busy", busy, 1);
    chk("beat_err", beat_err, nbeats != BEATS);
    chk("wdog_ack", wdog_err, 0);
    chk("vec_stable", vt_vector, ev);
    tick();
    chk("idle_gap", {ack, gnt, busy}, 0);
    rr = (w + 1) % NREQ;
  endtask

  initial begin
    int w;
    reset_n = 1'b0; req = '0; valid = 1'b0; done = 1'b0;
    new_vecs();

    // Held in reset: nothing moves regardless of inputs.
    for (int i = 0; i < 4; i++) begin
      req = NREQ'($urandom_range(1, 3)); valid = 1'($urandom_range(0, 1)); done = 1'($urandom_range(0, 1));
      tick();
      chk("rst_out", {gnt, ack, busy, rdy, beat_err, wdog_err, beat_cnt}, 0);
      chk("rst_vec", vt_vector, 0);
    end
    req = '0; valid = 1'b0; done = 1'b0;
    reset_n = 1'b1;
    tick();

    // Single job with a known vector.
    vecs[0] = {8{32'h3FC00000}};
    req_vec = vecs;
    req = 2'b01;
    run_job(2, 1'b0, 1'b0, 1'b0);

    // Beats/done while idle are ignored.
    req = '0; valid = 1'b1; done = 1'b1;
    tick();
    chk("idle_ign", {busy, gnt, ack}, 0);
    chk("idle_cnt", beat_cnt, 2);
    valid = 1'b0; done = 1'b0;

    // Contention: alternating grants.
    req = 2'b11;
    for (int j = 0; j < 4; j++) run_job(2, j[0], 1'b0, 1'b0);

    // Beat mismatch, then a clean job.
    req = 2'b01;
    run_job(1, 1'b0, 1'b0, 1'b0);
    run_job(2, 1'b0, 1'b0, 1'b0);

    // Requester drops req mid-job; still acked.
    req = 2'b10;
    run_job(2, 1'b0, 1'b0, 1'b1);

    // Mid-job reset: make rr point at 1 first so the restart proves rr went back to 0.
    req = 2'b01;
    run_job(2, 1'b0, 1'b0, 1'b0);
    req = 2'b11;
    tick();
    chk("pre_rst_gnt", gnt, 2'b10);
    valid = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst", {gnt, ack, busy, rdy, beat_cnt, beat_err}, 0);
    chk("mid_rst_vec", vt_vector, 0);
    valid = 1'b0;
    tick();
    reset_n = 1'b1;
    rr = 0;
    run_job(2, 1'b0, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      int nb;
      req = NREQ'($urandom_range(1, 3));
      nb  = $urandom_range(0, 4);
      run_job(nb, 1'($urandom_range(0, 1)), nb <= 3, $urandom_range(0, 3) == 0);
    end

    // Job that never sees done.
    req = 2'b01;
    w = rr_pick(req, rr);
    tick();
    chk("wd_gnt", gnt, 1 << w);
`ifdef BFP_VT_WDOG_EN
    begin
      int n;
      n = 0;
      while (ack == '0 && n < 20) begin tick(); n++; end
      chk("wd_lat", n, WDOG);
      chk("wd_ack", ack, 1 << w);
      chk("wd_err", {wdog_err, beat_err, rdy}, 3'b110);
      tick();
      chk("wd_idle", {busy, wdog_err}, 0);
    end
`else
    repeat (100) tick();
    chk("nowd_run", {gnt, rdy, busy, wdog_err}, {2'(1 << w), 1'b1, 1'b1, 1'b0});
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("nowd_ack", {ack, wdog_err, beat_err}, {2'(1 << w), 1'b0, 1'b1});
    tick();
    chk("nowd_idle", busy, 0);
`endif
    rr = (w + 1) % NREQ;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
